// File: rtl/ds1302_cmd_arbiter_pkg.sv
// Shared definitions for blocks that drive the ds1302_module command port:
// one-hot command codes, arbiter FSM encoding and counter widths.
package ds1302_cmd_arbiter_pkg;

    // One-hot command codes understood by ds1302_module
    localparam logic [7:0] WR_UNPROTECT = 8'h80;
    localparam logic [7:0] WR_HOUR      = 8'h40;
    localparam logic [7:0] WR_MIN       = 8'h20;
    localparam logic [7:0] WR_SEC       = 8'h10;
    localparam logic [7:0] WR_PROTECT   = 8'h08;
    localparam logic [7:0] RD_HOUR      = 8'h04;
    localparam logic [7:0] RD_MIN       = 8'h02;
    localparam logic [7:0] RD_SEC       = 8'h01;

    // Counter widths for the command arbiter
    localparam int CMD_W = 8;
    localparam int TO_W  = 24;
    localparam int GAP_W = 4;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // A command is legal only if it is exactly one of the eight known codes,
    // which for an 8-bit one-hot space is the same as "exactly one bit set".
    function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
        case (cmd)
            WR_UNPROTECT, WR_HOUR, WR_MIN, WR_SEC,
            WR_PROTECT, RD_HOUR, RD_MIN, RD_SEC: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ds1302_cmd_arbiter_rr.sv
// Combinational round-robin picker: starting one past the pointer and
// wrapping modulo NUM_REQ, returns the first asserted request.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt,
    output logic               valid
);

    // Candidate index, one bit wider so ptr + offset cannot overflow before wrap
    logic [IDX_W:0] cand;

    // Walk the requesters in rotating priority order and keep the first hit
    always_comb begin
        // NOTE: every output and temporary gets a default first so no path
        // through the loop leaves a value unassigned (that would infer a latch).
        gnt   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            // NOTE: blocking assignments here model a chain of combinational
            // updates; each iteration sees the value the previous one wrote.
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                gnt   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ds1302_cmd_arbiter.sv
// Shares one ds1302_module command port between NUM_REQ requesters.
// Round-robin grant, command held until cmd_done_i or timeout, then a
// fixed cmd-low gap so ds1302_module can settle before the next command.
module ds1302_cmd_arbiter
    import ds1302_cmd_arbiter_pkg::*;
#(
    parameter  int                NUM_REQ     = 2,
    parameter  logic [TO_W-1:0]   TIMEOUT_CYC = 24'd2_000_000,
    parameter  logic [GAP_W-1:0]  GAP_CYC     = 4'd2,
    localparam int                IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [CMD_W*NUM_REQ-1:0]   req_cmd_i,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [NUM_REQ-1:0]         err_o,
    output logic [CMD_W-1:0]           rdata_o,
    output logic                       busy_o,
    output logic [CMD_W-1:0]           cmd_o,
    input  logic                       cmd_done_i,
    input  logic [CMD_W-1:0]           read_data_i
);

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_q;      // last granted requester
    logic [IDX_W-1:0]  gnt_q;     // requester owning the current transaction
    logic [TO_W-1:0]   to_cnt;    // cycles spent in ISSUE
    logic [GAP_W-1:0]  gap_cnt;   // cycles spent in GAP

    logic [IDX_W-1:0]  arb_gnt;
    logic              arb_valid;
    logic [CMD_W-1:0]  cmd_slice [NUM_REQ];
    logic [CMD_W-1:0]  sel_cmd;

    // Unpack the flat command bus so a requester index selects its byte
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign cmd_slice[k] = req_cmd_i[CMD_W*k +: CMD_W];
    end

    assign sel_cmd = cmd_slice[arb_gnt];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_i),
        .ptr   (rr_q),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // One-hot requester mask for the done/err pulses
    function automatic logic [NUM_REQ-1:0] req_mask(input logic [IDX_W-1:0] idx);
        req_mask      = '0;
        req_mask[idx] = 1'b1;
    endfunction

    // Arbiter FSM with registered outputs: grant, hold command, then gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr_q    <= IDX_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            to_cnt  <= '0;
            gap_cnt <= '0;
            cmd_o   <= '0;
            done_o  <= '0;
            err_o   <= '0;
            rdata_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register in this block
            // samples pre-edge values regardless of statement order.
            // done/err are single-cycle pulses; they fall unless set below.
            done_o <= '0;
            err_o  <= '0;

            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt_q  <= arb_gnt;
                        rr_q   <= arb_gnt;
                        busy_o <= 1'b1;
                        if (cmd_is_legal(sel_cmd)) begin
                            cmd_o  <= sel_cmd;
                            to_cnt <= '0;
                            state  <= ST_ISSUE;
                        end else begin
                            // Malformed command: report at once, never drive it
                            done_o  <= req_mask(arb_gnt);
                            err_o   <= req_mask(arb_gnt);
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (cmd_done_i) begin
                        // Completion beats a coincident timeout
                        rdata_o <= read_data_i;
                        done_o  <= req_mask(gnt_q);
                        cmd_o   <= '0;
                        to_cnt  <= '0;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (to_cnt == TIMEOUT_CYC - TO_W'(1)) begin
                        done_o  <= req_mask(gnt_q);
                        err_o   <= req_mask(gnt_q);
                        cmd_o   <= '0;
                        to_cnt  <= '0;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ST_GAP: begin
                    // cmd_done_i is deliberately ignored here (stale pulse)
                    if (gap_cnt == GAP_CYC - GAP_W'(1)) begin
                        gap_cnt <= '0;
                        busy_o  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    cmd_o  <= '0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ds1302_cmd_arbiter.sv
// Self-checking bench for ds1302_cmd_arbiter: directed scenarios followed by
// randomized traffic, all predicted by a transaction-level reference model.
module tb_ds1302_cmd_arbiter;

    localparam int NR  = 2;
    localparam int TO  = 16;
    localparam int GAP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_i;
    logic [8*NR-1:0]   req_cmd_i;
    logic [NR-1:0]     done_o;
    logic [NR-1:0]     err_o;
    logic [7:0]        rdata_o;
    logic              busy_o;
    logic [7:0]        cmd_o;
    logic              cmd_done_i;
    logic [7:0]        read_data_i;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    int          last;           // most recently granted requester
    logic [NR-1:0] pend;         // requesters currently asking
    logic [7:0]  mcmd [NR];      // command each requester presents
    logic [7:0]  exp_rdata;      // value rdata_o must hold

    ds1302_cmd_arbiter #(
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (24'(TO)),
        .GAP_CYC     (4'(GAP))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .req_cmd_i   (req_cmd_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .cmd_o       (cmd_o),
        .cmd_done_i  (cmd_done_i),
        .read_data_i (read_data_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next grant: first asking requester after the last one, wrapping around
    function automatic int pick(input logic [NR-1:0] p, input int l);
        for (int k = 1; k <= NR; k++) begin
            if (p[(l + k) % NR]) return (l + k) % NR;
        end
        return 0;
    endfunction

    task automatic set_req(input int k, input logic [7:0] c);
        mcmd[k] = c;
        req_cmd_i[8*k +: 8] = c;
        pend[k] = 1'b1;
        req_i[k] = 1'b1;
    endtask

    function automatic logic [7:0] rand_cmd();
        logic [7:0] one = 8'h80;
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return one >> $urandom_range(0, 7);
    endfunction

    // Run one transaction for requester g, starting in an IDLE cycle.
    // lat: cycle (counted from the first cmd_o cycle) in which cmd_done_i
    // pulses; lat >= TO means the responder never answers.
    task automatic serve(input int g, input bit drop, input bit drop_early,
                         input int lat, input logic [7:0] rd,
                         input bit stale, input bit scramble);
        logic [7:0]    cmd;
        logic [NR-1:0] mask;
        bit            legal;
        bit            exp_err;
        int            fin;
        cmd  = mcmd[g];
        mask = '0;
        mask[g] = 1'b1;
        legal = ($countones(cmd) == 1);
        step();
        check("grant_busy", 8'(busy_o), 8'd1);
        if (legal) begin
            fin     = (lat < TO) ? lat + 1 : TO;
            exp_err = (lat >= TO);
            for (int c = 0; c < fin; c++) begin
                check("issue_cmd", cmd_o, cmd);
                check("issue_no_done", 8'(done_o), 8'd0);
                if (scramble && c == 1) req_cmd_i[8*g +: 8] = ~cmd;
                if (drop_early && c == 1) req_i[g] = 1'b0;
                cmd_done_i  = (c == lat);
                read_data_i = (c == lat) ? rd : 8'($urandom);
                step();
            end
            cmd_done_i = 1'b0;
            if (!exp_err) exp_rdata = rd;
        end else begin
            exp_err = 1'b1;
        end
        check("done_mask", 8'(done_o), 8'(mask));
        check("err_mask", 8'(err_o), exp_err ? 8'(mask) : 8'd0);
        check("done_cmd_low", cmd_o, 8'd0);
        check("done_rdata", rdata_o, exp_rdata);
        req_cmd_i[8*g +: 8] = mcmd[g];
        if (drop || drop_early) req_i[g] = 1'b0;
        cmd_done_i  = stale;
        read_data_i = 8'($urandom);
        step();
        cmd_done_i = 1'b0;
        for (int k = 1; k < GAP; k++) begin
            check("gap_busy", 8'(busy_o), 8'd1);
            check("gap_cmd_low", cmd_o, 8'd0);
            check("gap_no_done", 8'(done_o), 8'd0);
            step();
        end
        check("idle_busy", 8'(busy_o), 8'd0);
        check("idle_cmd_low", cmd_o, 8'd0);
        check("idle_no_done", 8'(done_o), 8'd0);
        check("idle_rdata_held", rdata_o, exp_rdata);
    endtask

    initial begin
        int g;
        int lat;
        int r;
        bit de;
        bit dr;

        // Reset
        rst = 1'b1;
        req_i = '0;
        req_cmd_i = '0;
        cmd_done_i = 1'b0;
        read_data_i = 8'h00;
        for (int k = 0; k < NR; k++) mcmd[k] = 8'h00;
        repeat (3) step();
        check("rst_cmd", cmd_o, 8'd0);
        check("rst_done", 8'(done_o), 8'd0);
        check("rst_err", 8'(err_o), 8'd0);
        check("rst_rdata", rdata_o, 8'd0);
        check("rst_busy", 8'(busy_o), 8'd0);
        rst = 1'b0;
        step();
        last = NR - 1;
        pend = '0;
        exp_rdata = 8'h00;

        // Contention: both held high, each completes in 5 cycles
        set_req(0, 8'h01);
        set_req(1, 8'h02);
        for (int i = 0; i < 4; i++) begin
            g = pick(pend, last);
            serve(g, 1'b0, 1'b0, 4, 8'hA0 + 8'(i), 1'b0, 1'b0);
            last = g;
        end
        req_i = '0;
        pend  = '0;

        // Single read request, answer 10 cycles after cmd_o
        set_req(0, 8'h04);
        g = pick(pend, last);
        serve(g, 1'b1, 1'b0, 10, 8'h23, 1'b0, 1'b0);
        last = g; pend[g] = 1'b0;

        // Illegal (two-hot) command
        set_req(1, 8'h06);
        g = pick(pend, last);
        serve(g, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        last = g; pend[g] = 1'b0;

        // Timeout: responder never answers
        set_req(0, 8'h20);
        g = pick(pend, last);
        serve(g, 1'b1, 1'b0, TO + 100, 8'h00, 1'b0, 1'b0);
        last = g; pend[g] = 1'b0;

        // Completion on the exact timeout cycle, plus a stale pulse in GAP
        set_req(1, 8'h01);
        g = pick(pend, last);
        serve(g, 1'b1, 1'b0, TO - 1, 8'h5A, 1'b1, 1'b0);
        last = g; pend[g] = 1'b0;

        // Reset while a write is in flight
        set_req(0, 8'h40);
        g = pick(pend, last);
        step();
        step();
        step();
        check("pre_rst_cmd", cmd_o, mcmd[g]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_cmd", cmd_o, 8'd0);
        check("mid_rst_busy", 8'(busy_o), 8'd0);
        check("mid_rst_done", 8'(done_o), 8'd0);
        check("mid_rst_rdata", rdata_o, 8'd0);
        last = NR - 1;
        exp_rdata = 8'h00;
        req_i = '0;
        pend  = '0;
        set_req(0, 8'h40);
        set_req(1, 8'h02);
        g = pick(pend, last);
        serve(g, 1'b1, 1'b0, 3, 8'h77, 1'b0, 1'b0);
        last = g; pend[g] = 1'b0;

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < NR; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) set_req(k, rand_cmd());
            end
            if (pend == '0) set_req($urandom_range(0, NR - 1), rand_cmd());
            g = pick(pend, last);
            r = $urandom_range(0, 9);
            if (r == 0)      lat = TO + 5;
            else if (r == 1) lat = TO - 1;
            else             lat = $urandom_range(0, 12);
            de = ($urandom_range(0, 5) == 0);
            dr = de ? 1'b0 : ($urandom_range(0, 3) != 0);
            serve(g, dr, de, lat, 8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0);
            last = g;
            if (dr || de) pend[g] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ds1302_cmd_arbiter.md
Name: ds1302_cmd_arbiter

Overview:
Shares one ds1302_module command port (one-hot 8-bit cmd / cmd_done / read_data) among NUM_REQ independent requesters. Typical requesters are the periodic time-readout sequencer and a set-time writer. The block sits between them and ds1302_module in the demo top. It provides round-robin arbitration, holds each command until completion, and inserts the mandatory cmd-low gap between transactions. It also rejects malformed commands and aborts hung transactions.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TIMEOUT_CYC, 24'd2_000_000, cycles to wait for cmd_done before abort (40 ms at 50 MHz)
GAP_CYC, 4'd2, cycles cmd_o held at 0 between transactions (min 1)

Ports:
clk  in  1  system clock (PLL output)
rst  in  1  synchronous, active-high reset
req_i  in  NUM_REQ  per-requester request level, held until its done pulse
req_cmd_i  in  8*NUM_REQ  per-requester one-hot command; slice k = bits [8k+7:8k]
done_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
err_o  out  NUM_REQ  one-cycle error flag, coincident with done_o
rdata_o  out  8  read byte captured at completion; valid while done_o is high, then held
busy_o  out  1  high from grant through the end of the gap
cmd_o  out  8  command to ds1302_module
cmd_done_i  in  1  completion pulse from ds1302_module
read_data_i  in  8  read data from ds1302_module

Behaviour:
- Reset values (rst sampled high on a clk edge):
  - cmd_o=0, done_o=0, err_o=0, rdata_o=0, busy_o=0.
  - State=IDLE; rr pointer=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - Scan req_i starting at rr+1, wrapping modulo NUM_REQ. The first asserted requester g is granted.
  - Latch g and req_cmd_i[g], set rr<=g, set busy_o=1.
  - One-hot check: if the latched cmd is zero or not one-hot, pulse done_o[g] and err_o[g] on the next edge. Nothing is issued; go to GAP.
  - Otherwise drive cmd_o=cmd on the next edge and go to ISSUE. Grant-to-cmd_o latency is 1 cycle.
- ISSUE:
  - Hold cmd_o stable. Increment the timeout counter each cycle.
  - On cmd_done_i=1:
    - rdata_o<=read_data_i; done_o[g]=1 for one cycle; cmd_o<=0.
    - Clear the counter; go to GAP.
    - rdata_o is updated for write commands too; the value has no meaning for writes.
  - When the counter reaches TIMEOUT_CYC-1 with no cmd_done_i: done_o[g]=1, err_o[g]=1, cmd_o<=0, go to GAP.
  - If cmd_done_i and timeout occur in the same cycle, completion wins (err_o=0).
- GAP:
  - cmd_o=0 for exactly GAP_CYC cycles, then go to IDLE with busy_o=0.
  - This lets ds1302_module return to idle before the next command.
  - A cmd_done_i arriving in GAP or IDLE is ignored; it is a stale pulse.
- Requester rules:
  - req_i and the requester's cmd slice must stay stable from assertion to its done pulse.
  - The requester drops req_i in the cycle after done. If req_i is still high on return to IDLE, it is treated as a new request, but round-robin gives other pending requesters priority.
- A change of req_cmd_i[g] during ISSUE is ignored; the latched copy is used.
- A deasserted req_i during ISSUE does not cancel the transaction; done_o still pulses.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0.
- Reset mid-transaction: all outputs return to reset values on the next edge. No done_o pulse is generated. The integrator resets ds1302_module from the same domain.
- Widths: the timeout counter is 24 bits and the gap counter is 4 bits. Neither wraps; both clear on each state entry.
- done_o and err_o are never asserted for more than one requester in the same cycle.

Decomposition:
- Shared package/header ds1302_defs:
  - Command one-hot constants: WR_UNPROTECT=8'h80, WR_HOUR=8'h40, WR_MIN=8'h20, WR_SEC=8'h10, WR_PROTECT=8'h08, RD_HOUR=8'h04, RD_MIN=8'h02, RD_SEC=8'h01.
  - FSM state encodings.
- One sub-module, rr_arbiter: combinational round-robin pick from (req, rr pointer), giving a grant index and a valid flag. Reused by later shared-resource blocks.

Test Plan:
- Single request: req_i=01, req_cmd=8'h04; cmd_done_i pulses 10 cycles after cmd_o, read_data_i=8'h23 -> cmd_o=8'h04 one cycle after grant; done_o=01 for one cycle with rdata_o=8'h23; cmd_o=0 for 2 cycles; busy_o falls.
- Contention: req_i=11 held continuously, each cmd completes in 5 cycles -> grant order 0,1,0,1; cmd_o never changes directly from one non-zero command to another without a ≥2-cycle zero gap.
- Illegal command: req_i=10, req_cmd slice1=8'h06 -> done_o=10 and err_o=10 two cycles after req; cmd_o stays 0 throughout.
- Timeout: TIMEOUT_CYC=16, cmd_done_i never asserted -> done_o and err_o pulse in the 16th cycle after cmd_o goes non-zero; cmd_o=0 the following cycle.
- Race and stale pulse: cmd_done_i on the exact timeout cycle -> err_o=0 and done_o=1; an extra cmd_done_i during GAP -> no done_o.
- Reset mid-ISSUE: rst=1 for one cycle while cmd_o=8'h40 -> cmd_o=0, busy_o=0, no done_o; the next request is granted to requester 0.
